nn_vec_mac_core: RTL
====================

// Module: nn_vec_mac_core
// PURPOSE
//  Parametrised successor of the single-output NN accelerator datapath.
//  Computes LANES neuron outputs in parallel over a streamed input vector of VEC_LEN activations.
//  Per beat: one activation broadcast to all lanes, each lane has its own weight.
//  Post-processing per lane: bias add, fixed-point scale, round, shift, saturate (optional ReLU).
//  Sits between the activation/weight feeders and the output writeback, with valid/ready on both sides.
// PARAMETERS
//  DATA_W   8   signed activation/weight width
//  ACC_W    32  signed accumulator and bias width
//  LANES    4   parallel output neurons
//  VEC_LEN  16  beats per operation (>=1)
//  SCALE_W  16  unsigned scale width
//  SHIFT    8   right shift after scaling (0 = none)
//  OUT_W    8   signed output width
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  start      in   1               begin operation; sampled only in IDLE
//  bias       in   LANES*ACC_W     per-lane signed bias; latched on accepted start
//  scale      in   SCALE_W         unsigned multiplier; latched on accepted start
//  in_valid   in   1               act/wt beat valid
//  in_ready   out  1               core accepts a beat
//  act        in   DATA_W          signed activation, broadcast to all lanes
//  wt         in   LANES*DATA_W    signed weights; lane i = wt[i*DATA_W +: DATA_W]
//  out_valid  out  1               out holds a result
//  out_ready  in   1               downstream accepts out
//  out        out  LANES*OUT_W     signed results; lane i = out[i*OUT_W +: OUT_W]
//  busy       out  1               high in every state except IDLE
//  done       out  1               one-cycle pulse after the output handshake
// BEHAVIOUR
//  Reset: state=IDLE; accumulators, beat counter, out, in_ready, out_valid, busy, done = 0.
//    Reset mid-operation aborts the operation; no done pulse is issued.
//  FSM
//    IDLE -> MAC on start (bias/scale latched, accumulators cleared).
//    MAC: in_ready=1; each in_valid&&in_ready beat does acc[i] += act*wt[i] and increments the counter.
//    MAC -> POST when the VEC_LEN-th beat is accepted.
//    POST (1 cycle, in_ready=0) computes results -> OUT.
//    OUT: out_valid=1, out held stable until out_ready. On handshake -> IDLE, done=1 next cycle.
//  Latency: last beat accepted at cycle t -> out_valid high from t+2.
//    Minimum operation length is start + VEC_LEN + 2 cycles.
//  Arithmetic, per lane, signed two's complement
//    Product is 2*DATA_W bits, sign-extended to ACC_W; accumulation wraps mod 2^ACC_W.
//    s = (acc + bias) wraps at ACC_W; p = s * {0,scale}, full ACC_W+SCALE_W+1 width.
//    If SHIFT>0, add 1<<(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
//    Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Boundaries
//    start while busy is ignored.
//    in_valid outside MAC is ignored (in_ready=0).
//    in_valid low in MAC stalls without state change.
//    out_ready high before out_valid has no effect.
//    done and a new start in the same cycle: start is accepted (state is IDLE then).
//    VEC_LEN=1: a single beat moves MAC -> POST.
// CONFIGURATION
//  NN_RELU_EN defined: after shift, negative values are forced to 0 before saturation;
//    outputs are always >= 0.
//  Undefined: no clamp; signed saturation only.
// TESTING (LANES=4, DATA_W=8, VEC_LEN=4, SHIFT=8, OUT_W=8, ACC_W=32)
//  1 act=1, wt=1 all lanes, bias=0, scale=256
//    -> out_valid at t+2, each lane out=4, done pulses once after handshake.
//  2 act=127, wt=127, bias=0, scale=256
//    -> acc=64516, every lane out=127 (saturated).
//  3 act=-2, wt=3, bias=0, scale=256
//    -> out=-24 (0xE8) without NN_RELU_EN, 0 with it.
//  4 lane0: 3 beats act=1 wt=1 plus 1 beat wt=0, bias=0, scale=128
//    -> 384+128=512, >>8 -> out=2 (1.5 rounds up).
//  5 in_valid toggled every other cycle, out_ready held low 5 cycles
//    -> results equal to case 1, out stable while waiting, done only after handshake.
//  6 rst pulsed after 2 MAC beats
//    -> all outputs 0 and IDLE immediately, no done.
//    Following start with case-1 data yields out=4.

Source files
------------

// File: rtl/nn_vec_mac_core.sv
// nn_vec_mac_core
//   Multi-lane neural-network MAC datapath. A streamed vector of VEC_LEN activations is
//   broadcast to LANES lanes, and each lane multiplies every activation by its own weight
//   and accumulates. After the last beat each lane adds its bias, scales, rounds, shifts
//   right and saturates to OUT_W bits. The result is then offered downstream under
//   valid/ready.
//
//   Optional feature: define NN_RELU_EN to clamp negative post-shift values to zero
//   before saturation.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            begin an operation (sampled only when idle); latches bias and scale
//   bias             per-lane signed bias, lane i = bias[i*ACC_W +: ACC_W]
//   scale            unsigned scale factor
//   in_valid/ready   activation/weight beat handshake
//   act              signed activation broadcast to every lane
//   wt               per-lane signed weights, lane i = wt[i*DATA_W +: DATA_W]
//   out_valid/ready  result handshake; out is held stable while out_valid is high
//   out              per-lane signed results, lane i = out[i*OUT_W +: OUT_W]
//   busy             high whenever the core is not idle
//   done             one-cycle pulse following the result handshake
module nn_vec_mac_core #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned LANES   = 4,
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned SCALE_W = 16,
    parameter int unsigned SHIFT   = 8,
    parameter int unsigned OUT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LANES*ACC_W-1:0]   bias,
    input  logic [SCALE_W-1:0]       scale,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        act,
    input  logic [LANES*DATA_W-1:0]  wt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out,
    output logic                     busy,
    output logic                     done
);

    // Full width of acc * {0,scale}; wide enough that rounding can never overflow.
    localparam int unsigned PW    = ACC_W + SCALE_W + 1;
    localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);
    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic [PW-1:0] RND = ({{(PW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [PW-1:0] OUT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] OUT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StPost, StOut} state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic [LANES*ACC_W-1:0]   bias_q;
    logic [SCALE_W-1:0]       scale_q;

    logic signed [2*DATA_W-1:0] beat_prod [LANES];
    logic [LANES*OUT_W-1:0]     post_res;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [ACC_W-1:0] sum;
        logic signed [PW-1:0]    prod;
        logic signed [PW-1:0]    shifted;
        logic [OUT_W-1:0]        res;

        assign beat_prod[i] = $signed(act) * $signed(wt[i*DATA_W +: DATA_W]);

        assign sum     = acc_q[i] + $signed(bias_q[i*ACC_W +: ACC_W]);
        assign prod    = PW'(sum) * PW'($signed({1'b0, scale_q}));
        assign shifted = (prod + $signed(RND)) >>> SHIFT;

        always_comb begin
            res = shifted[OUT_W-1:0];
            if (shifted > OUT_MAX) begin
                res = OUT_MAX[OUT_W-1:0];
            end else if (shifted < OUT_MIN) begin
                res = OUT_MIN[OUT_W-1:0];
            end
`ifdef NN_RELU_EN
            if (shifted[PW-1]) begin
                res = '0;
            end
`endif
        end

        assign post_res[i*OUT_W +: OUT_W] = res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bias_q    <= '0;
            scale_q   <= '0;
            out       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bias_q   <= bias;
                        scale_q  <= scale;
                        cnt_q    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StMac;
                        for (int i = 0; i < LANES; i++) begin
                            acc_q[i] <= '0;
                        end
                    end
                end
                StMac: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < LANES; i++) begin
                            acc_q[i] <= acc_q[i] + ACC_W'(beat_prod[i]);
                        end
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q    <= '0;
                            in_ready <= 1'b0;
                            state_q  <= StPost;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StPost: begin
                    out       <= post_res;
                    out_valid <= 1'b1;
                    state_q   <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
